preg_tracker: RTL and testbench
===============================

Name: preg_tracker

Overview:
- Physical-register bookkeeping block that produces the done_flags vector consumed by every issue-queue entry.
- Holds the free list of physical registers and hands one out per rename allocation; allocating clears that register's done flag.
- Writeback sets the flag again, which wakes waiting issue entries.
- Retirement returns superseded registers to the free list.
- Sits between rename (alloc port), execution writeback (wb port), retire (free port) and the issue queue (done_flags).

Parameters:
- NUM_PREGS, 30, number of physical registers; equals done_flags width.
- PREG_W, 5, physical register index width; must satisfy 2^PREG_W >= NUM_PREGS.
- NUM_ARCH, 4, physical registers 0..NUM_ARCH-1 hold the initial architectural state at reset.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- alloc_valid  in  1  rename requests a destination register this cycle.
- alloc_ready  out  1  free list non-empty; a register is available.
- alloc_preg  out  PREG_W  register handed out on alloc_valid && alloc_ready (head of free list).
- wb_valid  in  1  writeback of a result this cycle.
- wb_preg  in  PREG_W  register written back.
- free_valid  in  1  retire returns a register to the free list.
- free_preg  in  PREG_W  register returned.
- done_flags  out  NUM_PREGS  bit i = physical register i holds a valid value.
- free_count  out  PREG_W+1  number of entries currently in the free list.
- err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (async, rst=0):
  - done_flags = all ones.
  - The free list holds NUM_ARCH..NUM_PREGS-1 in ascending order: head=0, tail=NUM_PREGS-NUM_ARCH, free_count=NUM_PREGS-NUM_ARCH.
  - err=0, alloc_ready=1 (given NUM_ARCH < NUM_PREGS).
  - Reset mid-operation discards all pending state; nothing survives.
- Free list storage:
  - Circular FIFO of NUM_PREGS entries x PREG_W bits.
  - head and tail wrap from NUM_PREGS-1 to 0 (non-power-of-two modulus; explicit compare, not bit truncation).
  - free_count is the registered occupancy.
- Outputs:
  - alloc_ready = (free_count != 0), driven from registers only.
  - alloc_preg = fifo[head], combinational read of registered state.
  - No same-cycle bypass of a freed register to alloc.
- Alloc handshake:
  - On alloc_valid && alloc_ready: head advances and done_flags[alloc_preg] clears at the next edge.
  - alloc_valid with alloc_ready=0 has no effect and is not an error; rename must hold.
- Writeback:
  - On wb_valid: done_flags[wb_preg] sets at the next edge.
  - Wake-up latency is 1 cycle: issue entries see the flag the cycle after wb_valid.
- Free:
  - On free_valid: fifo[tail] <= free_preg, tail advances, count increments.
  - Always accepted.
  - If free_count == NUM_PREGS with no simultaneous alloc: ignore the push and set err.
- Simultaneous events:
  - alloc + free same cycle: count unchanged; both pointers advance. Legal when count == 0 (the push lands, alloc_ready is still 0 that cycle) and when count == NUM_PREGS.
  - alloc + wb to the same register: the clear wins. This is illegal upstream and also sets err.
  - wb and alloc to different registers: both apply.
- Out-of-range index (>= NUM_PREGS) on wb_preg or free_preg: the operation is ignored and err is set.
- err clears only on reset.

Decomposition:
- Shared package holds NUM_PREGS, PREG_W and NUM_ARCH so issue entries and rename share one definition of the done_flags width.
- One natural sub-module: preg_free_fifo, a circular FIFO with non-power-of-two wrap, reset-initialised contents, simultaneous push/pop, and count output.
- The done-flag register and error logic stay in the top level.

Test Plan:
- Reset, then sample: free_count=26, alloc_ready=1, alloc_preg=4, done_flags=30'h3FFFFFFF.
- Alloc 26 times back-to-back: alloc_preg sequence is 4..29, then alloc_ready=0 and done_flags=30'h0000000F. An extra alloc_valid changes nothing and err stays 0.
- Alloc reg 4, then wb_valid with wb_preg=4 the following cycle: done_flags[4] goes 1->0, then returns to 1 exactly one edge after wb_valid.
- Drain the list to empty, then free_valid with free_preg=2 together with alloc_valid: alloc not taken; next cycle free_count=1, alloc_ready=1, alloc_preg=2.
- Wrap: 30 alternating free/alloc pairs across the tail=29->0 boundary: the FIFO order is preserved and free_count is constant.
- Overflow: free with free_count=30 -> err=1, count stays 30. free_preg=31 -> ignored, err=1. Assert rst=0 mid-burst -> all state returns to reset values immediately (asynchronously).

Source files
------------

// File: rtl/preg_tracker_pkg.sv
// Shared physical-register constants and request type for rename, issue and writeback.
package preg_tracker_pkg;
    localparam int NUM_PREGS = 30;
    localparam int PREG_W    = 5;
    localparam int NUM_ARCH  = 4;
    localparam int CNT_W     = PREG_W + 1;

    typedef struct packed {
        logic              vld;
        logic [PREG_W-1:0] preg;
    } preg_req_t;
endpackage

// File: rtl/preg_free_fifo.sv
// Circular free-list FIFO with non-power-of-two wrap and reset-loaded contents.
module preg_free_fifo #(
    parameter int DEPTH     = 30,
    parameter int W         = 5,
    parameter int INIT_BASE = 4,
    parameter int INIT_N    = 26
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic [W:0]   count
);
    logic [DEPTH-1:0][W-1:0] mem;
    logic [W-1:0]            head;
    logic [W-1:0]            tail;

    // Pointers wrap by explicit compare since DEPTH need not be a power of two.
    function automatic logic [W-1:0] nxt(input logic [W-1:0] p);
        return (p == W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign head_data = mem[head];

    // Storage, pointers and occupancy; reset loads INIT_BASE.. in ascending order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= (i < INIT_N) ? W'(INIT_BASE + i) : '0;
            head  <= '0;
            tail  <= W'(INIT_N % DEPTH);
            count <= (W+1)'(INIT_N);
        end else begin
            if (push) begin
                mem[tail] <= push_data;
                tail      <= nxt(tail);
            end
            if (pop)
                head <= nxt(head);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/preg_tracker.sv
// Physical-register free list plus done-flag vector feeding issue-queue wakeup.
module preg_tracker
    import preg_tracker_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alloc_valid,
    output logic                 alloc_ready,
    output logic [PREG_W-1:0]    alloc_preg,
    input  logic                 wb_valid,
    input  logic [PREG_W-1:0]    wb_preg,
    input  logic                 free_valid,
    input  logic [PREG_W-1:0]    free_preg,
    output logic [NUM_PREGS-1:0] done_flags,
    output logic [CNT_W-1:0]     free_count,
    output logic                 err
);
    preg_req_t wb_req, free_req;
    logic      wb_ok, free_ok, alloc_fire, full, push, err_set;

    assign wb_req   = '{vld: wb_valid,   preg: wb_preg};
    assign free_req = '{vld: free_valid, preg: free_preg};

    // Out-of-range indices are dropped rather than aliased onto a real register.
    assign wb_ok      = wb_req.vld   && ({1'b0, wb_req.preg}   < CNT_W'(NUM_PREGS));
    assign free_ok    = free_req.vld && ({1'b0, free_req.preg} < CNT_W'(NUM_PREGS));
    assign alloc_ready = (free_count != '0);
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign full        = (free_count == CNT_W'(NUM_PREGS));
    // A push into a full list is only safe when an alloc frees a slot the same edge.
    assign push        = free_ok && (!full || alloc_fire);

    assign err_set = (wb_req.vld && !wb_ok) ||
                     (free_req.vld && !free_ok) ||
                     (free_ok && full && !alloc_fire) ||
                     (alloc_fire && wb_ok && (wb_req.preg == alloc_preg));

    preg_free_fifo #(
        .DEPTH    (NUM_PREGS),
        .W        (PREG_W),
        .INIT_BASE(NUM_ARCH),
        .INIT_N   (NUM_PREGS - NUM_ARCH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_data(free_req.preg),
        .pop      (alloc_fire),
        .head_data(alloc_preg),
        .count    (free_count)
    );

    // Done flags: alloc clears, writeback sets; clear wins on a same-register collision.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_flags <= '1;
        end else begin
            for (int i = 0; i < NUM_PREGS; i++) begin
                if (alloc_fire && (alloc_preg == PREG_W'(i)))
                    done_flags[i] <= 1'b0;
                else if (wb_ok && (wb_req.preg == PREG_W'(i)))
                    done_flags[i] <= 1'b1;
            end
        end
    end

    // Sticky protocol error, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         err <= 1'b0;
        else if (err_set) err <= 1'b1;
    end
endmodule

// File: tb/tb_preg_tracker.sv
// Self-checking bench: queue-based free-list model, constant vector table, corner sequences.
module tb_preg_tracker;
    import preg_tracker_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 alloc_valid, alloc_ready;
    logic [PREG_W-1:0]    alloc_preg;
    logic                 wb_valid;
    logic [PREG_W-1:0]    wb_preg;
    logic                 free_valid;
    logic [PREG_W-1:0]    free_preg;
    logic [NUM_PREGS-1:0] done_flags;
    logic [CNT_W-1:0]     free_count;
    logic                 err;

    always #5 clk = ~clk;

    preg_tracker dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_preg(alloc_preg),
        .wb_valid(wb_valid), .wb_preg(wb_preg),
        .free_valid(free_valid), .free_preg(free_preg),
        .done_flags(done_flags), .free_count(free_count), .err(err)
    );

    int checks = 0;
    int failures = 0;

    int                   fl[$];
    int                   exp_q[$];
    logic [NUM_PREGS-1:0] mdf;
    logic                 merr;

    typedef struct {
        bit a; bit w; int wp; bit f; int fp;
        int cnt; int preg; logic [NUM_PREGS-1:0] df; bit e;
    } vec_t;
    vec_t tbl[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        fl.delete();
        exp_q.delete();
        for (int i = NUM_ARCH; i < NUM_PREGS; i++) fl.push_back(i);
        mdf  = '1;
        merr = 1'b0;
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".count"}, 32'(free_count), fl.size());
        chk({tag, ".ready"}, 32'(alloc_ready), 32'(fl.size() != 0));
        chk({tag, ".done"},  32'(done_flags), 32'(mdf));
        chk({tag, ".err"},   32'(err), 32'(merr));
        if (fl.size() != 0) chk({tag, ".head"}, 32'(alloc_preg), fl[0]);
    endtask

    task automatic idle_inputs();
        alloc_valid = 0; wb_valid = 0; wb_preg = '0; free_valid = 0; free_preg = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
        check_state("reset");
    endtask

    // One clock of stimulus; the model advances alongside and the state is compared after the edge.
    task automatic cycle(input bit a, input bit w, input int wp, input bit f, input int fp);
        bit fire, ovf;
        int popped, sz, e;
        alloc_valid = a; wb_valid = w; wb_preg = PREG_W'(wp);
        free_valid = f; free_preg = PREG_W'(fp);
        #1;
        sz   = fl.size();
        fire = a && (sz != 0);
        if (a) chk("alloc_ready_now", 32'(alloc_ready), 32'(fire));
        if (fire) exp_q.push_back(fl[0]);
        if (fire && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("alloc_preg", 32'(alloc_preg), e);
        end
        ovf = f && (fp < NUM_PREGS) && (sz == NUM_PREGS) && !fire;
        if (w && wp >= NUM_PREGS) merr = 1'b1;
        if (f && fp >= NUM_PREGS) merr = 1'b1;
        if (ovf) merr = 1'b1;
        if (fire && w && wp == fl[0]) merr = 1'b1;
        popped = -1;
        if (fire) popped = fl.pop_front();
        if (f && fp < NUM_PREGS && !ovf) fl.push_back(fp);
        if (w && wp < NUM_PREGS) mdf[wp] = 1'b1;
        if (fire) mdf[popped] = 1'b0;
        @(posedge clk); #1;
        idle_inputs();
        check_state("cyc");
    endtask

    initial begin
        // a  w  wp  f  fp  cnt preg df            err
        tbl[0] = '{1, 0, 0,  0, 0, 25, 5, 30'h3FFFFFEF, 0};
        tbl[1] = '{0, 1, 4,  0, 0, 25, 5, 30'h3FFFFFFF, 0};
        tbl[2] = '{1, 1, 3,  0, 0, 24, 6, 30'h3FFFFFDF, 0};
        tbl[3] = '{0, 0, 0,  1, 5, 25, 6, 30'h3FFFFFDF, 0};
        tbl[4] = '{1, 0, 0,  1, 4, 25, 7, 30'h3FFFFF9F, 0};
        tbl[5] = '{0, 1, 31, 0, 0, 25, 7, 30'h3FFFFF9F, 1};
        tbl[6] = '{1, 1, 7,  0, 0, 24, 8, 30'h3FFFFF1F, 1};

        idle_inputs();
        do_reset();
        chk("rst_count", 32'(free_count), 26);
        chk("rst_ready", 32'(alloc_ready), 1);
        chk("rst_preg",  32'(alloc_preg), 4);
        chk("rst_done",  32'(done_flags), 32'h3FFFFFFF);
        chk("rst_err",   32'(err), 0);

        // Constant vectors: alloc/wb wake-up, mixed events, bad index, alloc/wb collision.
        for (int i = 0; i < 7; i++) begin
            cycle(tbl[i].a, tbl[i].w, tbl[i].wp, tbl[i].f, tbl[i].fp);
            chk($sformatf("tbl%0d_cnt", i),  32'(free_count), tbl[i].cnt);
            chk($sformatf("tbl%0d_preg", i), 32'(alloc_preg), tbl[i].preg);
            chk($sformatf("tbl%0d_done", i), 32'(done_flags), 32'(tbl[i].df));
            chk($sformatf("tbl%0d_err", i),  32'(err), 32'(tbl[i].e));
        end

        // Drain all 26 in order, then alloc on empty, then free+alloc on empty.
        do_reset();
        for (int i = 0; i < 26; i++) begin
            chk("drain_seq", 32'(alloc_preg), 4 + i);
            cycle(1, 0, 0, 0, 0);
        end
        chk("drain_ready", 32'(alloc_ready), 0);
        chk("drain_done",  32'(done_flags), 32'h0000000F);
        cycle(1, 0, 0, 0, 0);
        chk("empty_alloc_count", 32'(free_count), 0);
        chk("empty_alloc_err",   32'(err), 0);
        cycle(1, 0, 0, 1, 2);
        chk("empty_free_count", 32'(free_count), 1);
        chk("empty_free_ready", 32'(alloc_ready), 1);
        chk("empty_free_preg",  32'(alloc_preg), 2);

        // Wrap: simultaneous free/alloc across tail 29->0 keeps order and count.
        do_reset();
        for (int i = 0; i < 30; i++) begin
            cycle(1, 0, 0, 1, i);
            chk("wrap_count", 32'(free_count), 26);
        end
        chk("wrap_head", 32'(alloc_preg), 4);
        chk("wrap_err",  32'(err), 0);

        // Full list: alloc+free is legal, a lone free overflows.
        do_reset();
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, i);
        chk("full_count", 32'(free_count), 30);
        cycle(1, 0, 0, 1, 4);
        chk("full_swap_count", 32'(free_count), 30);
        chk("full_swap_err",   32'(err), 0);
        cycle(0, 0, 0, 1, 5);
        chk("ovf_count", 32'(free_count), 30);
        chk("ovf_err",   32'(err), 1);

        // Out-of-range free, then an async reset in the middle of an alloc burst.
        do_reset();
        cycle(0, 0, 0, 1, 31);
        chk("badfree_err",   32'(err), 1);
        chk("badfree_count", 32'(free_count), 26);
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0);
        alloc_valid = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk("async_count", 32'(free_count), 26);
        chk("async_ready", 32'(alloc_ready), 1);
        chk("async_preg",  32'(alloc_preg), 4);
        chk("async_done",  32'(done_flags), 32'h3FFFFFFF);
        chk("async_err",   32'(err), 0);
        @(posedge clk); #1;
        idle_inputs();
        rst = 1'b1;
        model_reset();
        check_state("post_async");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
